// File: rtl/foodfight_adc_ctrl.sv
// FoodFight multiplexed 8-bit ADC emulation: CPU-started sample/hold + fixed-length conversion.
// Optional `define FOODFIGHT_ADC_AUTOSCAN_EN adds background round-robin scanning into a cache.
module foodfight_adc_ctrl #(
  parameter int unsigned CONV_CYCLES = 96
) (
  input  logic       MCLK,
  input  logic       RESET,
  input  logic       START,
  input  logic [1:0] CHSEL,
  input  logic [7:0] AX0,
  input  logic [7:0] AY0,
  input  logic [7:0] AX1,
  input  logic [7:0] AY1,
  output logic [7:0] DOUT,
  output logic       BUSY,
  output logic       EOC
);

  typedef enum logic [1:0] {S_IDLE, S_SAMPLE, S_CONVERT} state_e;
  typedef enum logic {OWN_CPU, OWN_SCAN} owner_e;

  state_e     state_q, state_d;
  owner_e     owner_q, owner_d;
  logic [1:0] cur_ch_q, cur_ch_d;
  logic [7:0] hold_q, hold_d;
  logic [7:0] cnt_q, cnt_d;
  logic [7:0] dout_q, dout_d;
  logic       busy_q, busy_d;
  logic       eoc_q, eoc_d;
  logic [7:0] ch_val;
  logic       done;

`ifdef FOODFIGHT_ADC_AUTOSCAN_EN
  logic [1:0] scan_ch_q, scan_ch_d;
  logic [7:0] cache_q [4];
  logic [7:0] cache_d [4];
`endif

  assign done = (state_q == S_CONVERT) && (cnt_q == '0);

  always_comb begin
    case (cur_ch_q)
      2'd0:    ch_val = AX0;
      2'd1:    ch_val = AY0;
      2'd2:    ch_val = AX1;
      default: ch_val = AY1;
    endcase
  end

  always_ff @(posedge MCLK) begin
    if (RESET) state_q <= S_IDLE;
    else       state_q <= state_d;
  end

  // A START always restarts at SAMPLE, including on the completion edge.
  always_comb begin
    state_d = state_q;
    if (START) begin
      state_d = S_SAMPLE;
    end else begin
      case (state_q)
        S_IDLE: begin
`ifdef FOODFIGHT_ADC_AUTOSCAN_EN
          state_d = S_SAMPLE;
`endif
        end
        S_SAMPLE:  state_d = S_CONVERT;
        S_CONVERT: if (done) state_d = S_IDLE;
        default:   state_d = S_IDLE;
      endcase
    end
  end

  always_comb begin
    owner_d  = owner_q;
    cur_ch_d = cur_ch_q;
    hold_d   = hold_q;
    cnt_d    = cnt_q;
    dout_d   = dout_q;
    busy_d   = busy_q;
    eoc_d    = 1'b0;
`ifdef FOODFIGHT_ADC_AUTOSCAN_EN
    scan_ch_d = scan_ch_q;
    cache_d   = cache_q;
`endif
    if (START) begin
      cur_ch_d = CHSEL;
      owner_d  = OWN_CPU;
      busy_d   = 1'b1;
    end else begin
      case (state_q)
        S_IDLE: begin
`ifdef FOODFIGHT_ADC_AUTOSCAN_EN
          cur_ch_d = scan_ch_q;
          owner_d  = OWN_SCAN;
`endif
        end
        S_SAMPLE: begin
          hold_d = ch_val;
          cnt_d  = 8'(CONV_CYCLES - 1);
        end
        S_CONVERT: begin
          if (done) begin
            if (owner_q == OWN_CPU) begin
              dout_d = hold_q;
              eoc_d  = 1'b1;
              busy_d = 1'b0;
            end
`ifdef FOODFIGHT_ADC_AUTOSCAN_EN
            cache_d[cur_ch_q] = hold_q;
            if (owner_q == OWN_SCAN) scan_ch_d = scan_ch_q + 2'd1;
`endif
          end else begin
            cnt_d = cnt_q - 8'd1;
          end
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge MCLK) begin
    if (RESET) begin
      owner_q  <= OWN_CPU;
      cur_ch_q <= '0;
      hold_q   <= 8'h80;
      cnt_q    <= '0;
      dout_q   <= 8'h80;
      busy_q   <= 1'b0;
      eoc_q    <= 1'b0;
`ifdef FOODFIGHT_ADC_AUTOSCAN_EN
      scan_ch_q <= '0;
      cache_q   <= '{4{8'h80}};
`endif
    end else begin
      owner_q  <= owner_d;
      cur_ch_q <= cur_ch_d;
      hold_q   <= hold_d;
      cnt_q    <= cnt_d;
      dout_q   <= dout_d;
      busy_q   <= busy_d;
      eoc_q    <= eoc_d;
`ifdef FOODFIGHT_ADC_AUTOSCAN_EN
      scan_ch_q <= scan_ch_d;
      cache_q   <= cache_d;
`endif
    end
  end

  assign DOUT = dout_q;
  assign BUSY = busy_q;
  assign EOC  = eoc_q;

endmodule

// File: tb/tb_foodfight_adc_ctrl.sv
// Scoreboard bench for foodfight_adc_ctrl: stimulus pushes expected {DOUT, edge}; monitor checks on EOC.
module tb_foodfight_adc_ctrl;

  localparam int CONV = 96;

  logic       MCLK = 1'b0;
  logic       RESET = 1'b1;
  logic       START = 1'b0;
  logic [1:0] CHSEL = '0;
  logic [7:0] AX0 = 8'h80, AY0 = 8'h80, AX1 = 8'h80, AY1 = 8'h80;
  logic [7:0] DOUT;
  logic       BUSY, EOC;

  foodfight_adc_ctrl #(.CONV_CYCLES(CONV)) dut (
    .MCLK(MCLK), .RESET(RESET), .START(START), .CHSEL(CHSEL),
    .AX0(AX0), .AY0(AY0), .AX1(AX1), .AY1(AY1),
    .DOUT(DOUT), .BUSY(BUSY), .EOC(EOC)
  );

  always #5 MCLK = ~MCLK;

  typedef struct {
    logic [7:0] data;
    int         edge_n;
  } exp_t;

  exp_t sb[$];
  int   edge_cnt = 0;
  int   tests = 0;
  int   fails = 0;

  always @(posedge MCLK) edge_cnt <= edge_cnt + 1;

  // Monitor: every EOC must match the oldest expected result, at the expected edge.
  always @(negedge MCLK) begin
    if (!RESET && EOC) begin
      tests++;
      if (sb.size() == 0) begin
        fails++;
        $display("FAIL unexpected_eoc: edge %0d DOUT=%02h, none required", edge_cnt, DOUT);
      end else begin
        exp_t e;
        e = sb.pop_front();
        if (DOUT !== e.data || edge_cnt != e.edge_n) begin
          fails++;
          $display("FAIL eoc_result: got DOUT=%02h at edge %0d, required %02h at edge %0d",
                   DOUT, edge_cnt, e.data, e.edge_n);
        end
      end
    end
  end

  task automatic check(input string name, input logic [7:0] act, input logic [7:0] req);
    tests++;
    if (act !== req) begin
      fails++;
      $display("FAIL %s: got %02h, required %02h", name, act, req);
    end
  endtask

  // Pulse START for one edge; k returns the edge index that sampled it.
  task automatic start_conv(input logic [1:0] ch, output int k);
    @(negedge MCLK);
    START = 1'b1;
    CHSEL = ch;
    @(posedge MCLK);
    #1;
    k = edge_cnt;
    START = 1'b0;
  endtask

  task automatic wait_done(input string name);
    int n;
    n = 0;
    while (sb.size() != 0 && n < 400) begin
      @(posedge MCLK);
      n++;
    end
    #1;
    tests++;
    if (sb.size() != 0) begin
      fails++;
      $display("FAIL %s_timeout: %0d results outstanding, required 0", name, sb.size());
      sb.delete();
    end
  endtask

  initial begin
    int k, k2, drops;
    repeat (3) @(posedge MCLK);
    @(negedge MCLK);
    RESET = 1'b0;
    check("reset_dout", DOUT, 8'h80);
    check("reset_busy", {7'd0, BUSY}, 8'd0);
    check("reset_eoc", {7'd0, EOC}, 8'd0);

    // Basic conversion on AY0
    AY0 = 8'h3C;
    start_conv(2'd1, k);
    check("basic_busy_set", {7'd0, BUSY}, 8'd1);
    sb.push_back('{8'h3C, k + CONV + 1});
    wait_done("basic");
    check("basic_eoc_clear", {7'd0, EOC}, 8'd0);
    check("basic_busy_clear", {7'd0, BUSY}, 8'd0);
    check("basic_dout_hold", DOUT, 8'h3C);

    // Input changed after sampling must not affect the result
    AX1 = 8'h10;
    start_conv(2'd2, k);
    sb.push_back('{8'h10, k + CONV + 1});
    repeat (10) @(posedge MCLK);
    AX1 = 8'hF0;
    wait_done("hold");

    // Abort by a second START 40 cycles later; BUSY must never drop
    AX1 = 8'h77;
    AY1 = 8'hA5;
    drops = 0;
    start_conv(2'd2, k);
    for (int i = 0; i < 39; i++) begin
      @(negedge MCLK);
      if (!BUSY) drops++;
    end
    start_conv(2'd3, k2);
    sb.push_back('{8'hA5, k2 + CONV + 1});
    for (int i = 0; i < CONV; i++) begin
      @(negedge MCLK);
      if (!BUSY) drops++;
    end
    check("abort_busy_drops", 8'(drops), 8'd0);
    wait_done("abort");
    check("abort_dout", DOUT, 8'hA5);

    // START coinciding with the completion edge: restart wins
    AX0 = 8'h5A;
    AY0 = 8'hC3;
    start_conv(2'd0, k);
    repeat (CONV) @(posedge MCLK);
    start_conv(2'd1, k2);
    check("restart_dout_kept", DOUT, 8'hA5);
    check("restart_busy", {7'd0, BUSY}, 8'd1);
    check("restart_no_eoc", {7'd0, EOC}, 8'd0);
    sb.push_back('{8'hC3, k2 + CONV + 1});
    wait_done("restart");

    // Back-to-back: new START on the edge right after EOC
    AX0 = 8'h21;
    AY1 = 8'h9E;
    start_conv(2'd0, k);
    sb.push_back('{8'h21, k + CONV + 1});
    repeat (CONV + 1) @(posedge MCLK);
    start_conv(2'd3, k2);
    sb.push_back('{8'h9E, k2 + CONV + 1});
    wait_done("b2b");

    // Reset mid-conversion (cnt around 50) discards the result
    AY1 = 8'h05;
    start_conv(2'd3, k);
    repeat (46) @(posedge MCLK);
    @(negedge MCLK);
    RESET = 1'b1;
    @(posedge MCLK);
    #1;
    check("midreset_dout", DOUT, 8'h80);
    check("midreset_busy", {7'd0, BUSY}, 8'd0);
    check("midreset_eoc", {7'd0, EOC}, 8'd0);
    @(negedge MCLK);
    RESET = 1'b0;
    repeat (60) @(posedge MCLK);
    AX0 = 8'hE7;
    start_conv(2'd0, k);
    sb.push_back('{8'hE7, k + CONV + 1});
    wait_done("post_reset");

`ifdef FOODFIGHT_ADC_AUTOSCAN_EN
    begin
      int hi;
      logic [1:0] sc;
      logic [7:0] want [4];
      want[0] = 8'h11; want[1] = 8'h22; want[2] = 8'h33; want[3] = 8'h44;
      @(negedge MCLK);
      RESET = 1'b1;
      AX0 = 8'h11; AY0 = 8'h22; AX1 = 8'h33; AY1 = 8'h44;
      @(negedge MCLK);
      RESET = 1'b0;
      hi = 0;
      for (int i = 0; i < 4 * (CONV + 2) + 2; i++) begin
        @(negedge MCLK);
        if (BUSY || EOC) hi++;
      end
      for (int i = 0; i < 4; i++) check("scan_cache", dut.cache_q[i], want[i]);
      check("scan_status_quiet", 8'(hi), 8'd0);
      repeat (30) @(posedge MCLK);
      #1;
      sc = dut.scan_ch_q;
      start_conv(2'd2, k);
      sb.push_back('{8'h33, k + CONV + 1});
      wait_done("scan_preempt");
      check("scan_ch_kept", {6'd0, dut.scan_ch_q}, {6'd0, sc});
    end
`endif

    repeat (5) @(posedge MCLK);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
